fpu_share_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one multi-cycle floating-point unit between two requesters.
- Drives the select of the 2:1 operand multiplexer, issues a start pulse to the shared unit and waits for its completion.
- Returns the registered result to the granted requester with a one-cycle acknowledge.
- Guards against a hung unit with a timeout counter.

---
 rtl/fpu_share_arbiter_if.sv | 38 +++
 rtl/fpu_share_arbiter.sv | 126 ++++++++++++
 tb/tb_fpu_share_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_share_arbiter_if.sv
// Bus bundle between two requesters, the shared FPU and the arbiter.
// Requester side: req_0/1, data_0/1, ack_0/1, err_0/1, result.
// Unit side: ms, unit_operand, unit_start, unit_ready, unit_result.
// Status: busy.
// Ports of the slave modport (the arbiter) are seen from the arbiter.
interface fpu_share_arbiter_if #(
  parameter int unsigned P = 32
);
  logic         req_0;
  logic         req_1;
  logic [P-1:0] data_0;
  logic [P-1:0] data_1;
  logic         ms;
  logic [P-1:0] unit_operand;
  logic         unit_start;
  logic         unit_ready;
  logic [P-1:0] unit_result;
  logic [P-1:0] result;
  logic         ack_0;
  logic         ack_1;
  logic         err_0;
  logic         err_1;
  logic         busy;

  // Requesters plus the shared unit, driving the arbiter.
  modport master (
    output req_0, req_1, data_0, data_1, unit_ready, unit_result,
    input  ms, unit_operand, unit_start, result,
           ack_0, ack_1, err_0, err_1, busy
  );

  // The arbiter itself.
  modport slave (
    input  req_0, req_1, data_0, data_1, unit_ready, unit_result,
    output ms, unit_operand, unit_start, result,
           ack_0, ack_1, err_0, err_1, busy
  );
endinterface

// File: rtl/fpu_share_arbiter.sv
// Round-robin sequencer sharing one multi-cycle FPU between two requesters.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fpu_share_arbiter_if.slave: requests/operands in, mux select,
//          start pulse, result, ack/err strobes and busy out; unit_ready
//          and unit_result in from the shared unit.
// All outputs are registered except unit_operand (the operand mux).
module fpu_share_arbiter #(
  parameter int unsigned P     = 32,
  parameter int unsigned TMO   = 255,
  parameter int unsigned TMO_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  fpu_share_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO);

  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             ms_q, ms_d;
  logic [P-1:0]     result_q, result_d;
  logic             start_q, start_d;
  logic             ack_0_q, ack_1_q, err_0_q, err_1_q;
  logic             ack_d, err_d;
  logic             busy_q;

  // Next-state and next-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    ms_d     = ms_q;
    result_d = result_q;
    start_d  = 1'b0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie, the requester not granted last time wins.
        if (bus.req_0 && (!bus.req_1 || last_q)) begin
          ms_d    = 1'b0;
          last_d  = 1'b0;
          start_d = 1'b1;
          state_d = LOAD;
        end else if (bus.req_1) begin
          ms_d    = 1'b1;
          last_d  = 1'b1;
          start_d = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // Completion takes priority over a timeout in the same cycle.
        if (bus.unit_ready) begin
          result_d = bus.unit_result;
          ack_d    = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == TMO_LIMIT) begin
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d    = cnt_q + TMO_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      ms_q     <= 1'b0;
      result_q <= '0;
      start_q  <= 1'b0;
      ack_0_q  <= 1'b0;
      ack_1_q  <= 1'b0;
      err_0_q  <= 1'b0;
      err_1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      ms_q     <= ms_d;
      result_q <= result_d;
      start_q  <= start_d;
      ack_0_q  <= ack_d & ~ms_q;
      ack_1_q  <= ack_d &  ms_q;
      err_0_q  <= err_d & ~ms_q;
      err_1_q  <= err_d &  ms_q;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.ms           = ms_q;
  assign bus.unit_operand = ms_q ? bus.data_1 : bus.data_0;
  assign bus.unit_start   = start_q;
  assign bus.result       = result_q;
  assign bus.ack_0        = ack_0_q;
  assign bus.ack_1        = ack_1_q;
  assign bus.err_0        = err_0_q;
  assign bus.err_1        = err_1_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed bench for fpu_share_arbiter with TMO = 4.
module tb_fpu_share_arbiter;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  fpu_share_arbiter_if #(.P(32)) bus ();

  fpu_share_arbiter #(.P(32), .TMO(4), .TMO_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ms"},     32'(bus.ms), 32'd0);
    chk({tag, "_start"},  32'(bus.unit_start), 32'd0);
    chk({tag, "_acks"},   32'({bus.ack_0, bus.ack_1}), 32'd0);
    chk({tag, "_errs"},   32'({bus.err_0, bus.err_1}), 32'd0);
    chk({tag, "_busy"},   32'(bus.busy), 32'd0);
    chk({tag, "_result"}, bus.result, 32'd0);
  endtask

  // Wait (bounded) for unit_start, check the grant, then deliver
  // unit_ready dly cycles after unit_start. Returns in the RESP cycle.
  task automatic serve(input int who, input int dly, input logic [31:0] op,
                       input logic [31:0] res, input string tag);
    int n;
    n = 0;
    while (bus.unit_start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_start"}, 32'(bus.unit_start), 32'd1);
    chk({tag, "_ms"}, 32'(bus.ms), 32'(who));
    chk({tag, "_operand"}, bus.unit_operand, op);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < dly; i++) step();
    chk({tag, "_start_low"}, 32'(bus.unit_start), 32'd0);
    bus.unit_ready  = 1'b1;
    bus.unit_result = res;
    step();
    bus.unit_ready  = 1'b0;
    bus.unit_result = 32'hFFFF_FFFF;
    chk({tag, "_ack"}, 32'({bus.ack_1, bus.ack_0}), (who == 0) ? 32'd1 : 32'd2);
    chk({tag, "_err"}, 32'({bus.err_1, bus.err_0}), 32'd0);
    chk({tag, "_result"}, bus.result, res);
  endtask

  // RESP -> IDLE: strobes drop, busy drops, no back-to-back start.
  task automatic to_idle(input string tag);
    step();
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_idle_strobes"},
        32'({bus.ack_0, bus.ack_1, bus.err_0, bus.err_1, bus.unit_start}), 32'd0);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    bus.req_0       = 1'b0;
    bus.req_1       = 1'b0;
    bus.data_0      = '0;
    bus.data_1      = '0;
    bus.unit_ready  = 1'b0;
    bus.unit_result = '0;

    // Reset values
    #2;
    chk_all_zero("reset");
    step();
    step();
    rst = 1'b0;

    // Single request, ready 3 cycles after start
    bus.req_0  = 1'b1;
    bus.data_0 = 32'h3F80_0000;
    serve(0, 3, 32'h3F80_0000, 32'h0000_0000, "single");
    chk("single_ack1", 32'(bus.ack_1), 32'd0);
    chk("single_resp_busy", 32'(bus.busy), 32'd1);
    bus.req_0 = 1'b0;
    to_idle("single");
    step();
    chk("single_stays_idle", 32'(bus.busy), 32'd0);

    // Simultaneous requests after reset: 0, 1, 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_0  = 1'b1;
    bus.req_1  = 1'b1;
    bus.data_0 = 32'h4000_0000;
    bus.data_1 = 32'h4040_0000;
    serve(0, 1, 32'h4000_0000, 32'h1111_1111, "tie1");
    to_idle("tie1");
    serve(1, 2, 32'h4040_0000, 32'h2222_2222, "tie2");
    to_idle("tie2");
    serve(0, 1, 32'h4000_0000, 32'h3333_3333, "tie3");
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    to_idle("tie3");

    // Timeout: err_1 exactly TMO+2 = 6 cycles after unit_start
    bus.req_1  = 1'b1;
    bus.data_1 = 32'hC000_0000;
    step();
    chk("tmo_start", 32'(bus.unit_start), 32'd1);
    chk("tmo_ms", 32'(bus.ms), 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("tmo_err_early", 32'(bus.err_1), 32'd0);
    step();
    chk("tmo_err1", 32'(bus.err_1), 32'd1);
    chk("tmo_others", 32'({bus.ack_0, bus.ack_1, bus.err_0}), 32'd0);
    chk("tmo_result_held", bus.result, 32'h3333_3333);
    bus.req_1 = 1'b0;
    to_idle("tmo");
    bus.req_0 = 1'b1;
    serve(0, 2, 32'h4000_0000, 32'h4444_4444, "after_tmo");
    bus.req_0 = 1'b0;
    to_idle("after_tmo");

    // Asynchronous reset while in RUN on requester 1
    bus.req_1 = 1'b1;
    step();
    chk("rstrun_start", 32'(bus.unit_start), 32'd1);
    step();
    step();
    chk("rstrun_ms_before", 32'(bus.ms), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rstrun");
    bus.req_0 = 1'b1;
    step();
    rst = 1'b0;
    serve(0, 1, 32'h4000_0000, 32'h5555_5555, "rst_tie");
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    to_idle("rst_tie");

    // Race: ready in the cycle the counter reaches TMO
    bus.req_1 = 1'b1;
    serve(1, 5, 32'hC000_0000, 32'h6666_6666, "race");
    bus.req_1 = 1'b0;
    to_idle("race");

    // Spurious unit_ready in IDLE then in LOAD
    bus.unit_ready  = 1'b1;
    bus.unit_result = 32'hDEAD_DEAD;
    step();
    bus.unit_ready  = 1'b0;
    chk("spur_idle_strobes", 32'({bus.ack_0, bus.ack_1, bus.err_0, bus.err_1}), 32'd0);
    chk("spur_idle_result", bus.result, 32'h6666_6666);
    bus.req_0 = 1'b1;
    step();
    chk("spur_load_start", 32'(bus.unit_start), 32'd1);
    bus.unit_ready  = 1'b1;
    bus.unit_result = 32'hBEEF_BEEF;
    step();
    bus.unit_ready  = 1'b0;
    step();
    chk("spur_load_strobes", 32'({bus.ack_0, bus.ack_1, bus.err_0, bus.err_1}), 32'd0);
    chk("spur_load_result", bus.result, 32'h6666_6666);
    bus.unit_ready  = 1'b1;
    bus.unit_result = 32'h7777_7777;
    step();
    bus.unit_ready  = 1'b0;
    chk("spur_real_ack", 32'({bus.ack_1, bus.ack_0}), 32'd1);
    chk("spur_real_result", bus.result, 32'h7777_7777);
    bus.req_0 = 1'b0;
    to_idle("spur");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
